// File: rtl/audio_pkg.sv
// Shared defaults and sample-field layout for the audio PWM sink.
package audio_pkg;

    localparam int unsigned DefSamplePeriod = 2268;
    localparam int unsigned DefPwmBits      = 8;
    localparam int unsigned DefFifoDepth    = 4;

    localparam int unsigned SampleW   = 16;
    localparam int unsigned SampleMsb = 15;
    localparam int unsigned SampleLsb = 0;

    typedef logic [SampleW-1:0] sample_t;

endpackage

// File: rtl/audio_fifo.sv
// Power-of-two sample FIFO; ready_o is a registered "not full" derived from the next level.
module audio_fifo
    import audio_pkg::*;
#(
    parameter int unsigned Depth = DefFifoDepth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  sample_t                wdata_i,
    input  logic                   pop_i,
    output sample_t                rdata_o,
    output logic                   empty_o,
    output logic                   ready_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned     AddrW   = $clog2(Depth);
    localparam int unsigned     LvlW    = AddrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

    sample_t          mem_q [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push_i && (level_q != LvlFull);
        do_pop  = pop_i && (level_q != '0);
        wptr_d  = do_push ? wptr_q + AddrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AddrW'(1) : rptr_q;
        level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
        ready_d = (level_d != LvlFull);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ready_q <= ready_d;
        end
    end

    // Storage needs no reset: pointers and level discard stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (level_q == '0);
    assign ready_o = ready_q;
    assign level_o = level_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio stream sink: buffers samples, releases one per sample period and drives a 1-bit PWM pin.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = DefSamplePeriod,
    parameter int unsigned PWM_BITS      = DefPwmBits,
    parameter int unsigned FIFO_DEPTH    = DefFifoDepth
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 input_audio,
    input  logic                        input_audio_stb,
    output logic                        input_audio_ack,
    output logic                        audio_pwm,
    output logic                        audio_sd,
    output logic [15:0]                 underrun_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned         SpW      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [SpW-1:0]      SpMax    = SpW'(SAMPLE_PERIOD - 1);
    localparam logic [PWM_BITS-1:0] PwmMax   = '1;
    localparam logic [PWM_BITS-1:0] MidScale = {1'b1, {(PWM_BITS - 1){1'b0}}};

    logic [SpW-1:0]      sp_cnt_q, sp_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] pending_q, pending_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] head_duty;
    logic                sd_q, sd_d;
    logic [15:0]         uc_q, uc_d;
    logic                tick, pwm_wrap, push;
    logic                fifo_empty, fifo_ready;
    sample_t             fifo_head;
    logic                unused_hi_bits;

    assign unused_hi_bits = ^input_audio[31:SampleW];
    assign push           = input_audio_stb && fifo_ready;

    audio_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i (input_audio[SampleMsb:SampleLsb]),
        .pop_i   (tick),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready),
        .level_o (fifo_level)
    );

    // Flipping the sign bit turns the top bits of a two's-complement sample into offset binary.
    assign head_duty = fifo_head[SampleMsb -: PWM_BITS] ^ MidScale;

    always_comb begin
        tick      = (sp_cnt_q == SpMax);
        sp_cnt_d  = tick ? '0 : sp_cnt_q + SpW'(1);
        pwm_wrap  = (pwm_cnt_q == PwmMax);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pending_d = pending_q;
        if (tick && !fifo_empty) begin
            pending_d = head_duty;
        end
        duty_d = pwm_wrap ? pending_q : duty_q;
        sd_d   = sd_q | push;
        uc_d   = uc_q;
        if (tick && fifo_empty && sd_q && (uc_q != 16'hFFFF)) begin
            uc_d = uc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_cnt_q  <= '0;
            pwm_cnt_q <= '0;
            pending_q <= MidScale;
            duty_q    <= MidScale;
            sd_q      <= 1'b0;
            uc_q      <= '0;
        end else begin
            sp_cnt_q  <= sp_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            sd_q      <= sd_d;
            uc_q      <= uc_d;
        end
    end

    assign input_audio_ack = fifo_ready;
    assign audio_sd        = sd_q;
    assign audio_pwm       = (pwm_cnt_q < duty_q) && sd_q;
    assign underrun_count  = uc_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out; a second instance with a 1-clock period covers saturation.
module tb_audio_pwm_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] input_audio;
    logic        input_audio_stb;
    logic        input_audio_ack;
    logic        audio_pwm;
    logic        audio_sd;
    logic [15:0] underrun_count;
    logic [2:0]  fifo_level;

    logic        rst2;
    logic [31:0] audio2;
    logic        stb2;
    logic        ack2;
    logic        pwm2;
    logic        sd2;
    logic [15:0] uc2;
    logic [2:0]  lvl2;
    bit          done2 = 1'b0;

    int checks = 0;
    int errors = 0;

    audio_pwm_out #(
        .SAMPLE_PERIOD (64),
        .PWM_BITS      (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_audio     (input_audio),
        .input_audio_stb (input_audio_stb),
        .input_audio_ack (input_audio_ack),
        .audio_pwm       (audio_pwm),
        .audio_sd        (audio_sd),
        .underrun_count  (underrun_count),
        .fifo_level      (fifo_level)
    );

    audio_pwm_out #(
        .SAMPLE_PERIOD (1),
        .PWM_BITS      (4),
        .FIFO_DEPTH    (4)
    ) dut_sat (
        .clk             (clk),
        .rst             (rst2),
        .input_audio     (audio2),
        .input_audio_stb (stb2),
        .input_audio_ack (ack2),
        .audio_pwm       (pwm2),
        .audio_sd        (sd2),
        .underrun_count  (uc2),
        .fifo_level      (lvl2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just after a tick edge (FIFO empty, amplifier on).
    task automatic wait_tick(input string tag);
        logic [15:0] base;
        bit          hit;
        hit  = 1'b0;
        base = underrun_count;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (underrun_count != base) hit = 1'b1;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic send(input logic [31:0] word, input string tag);
        bit done;
        done            = 1'b0;
        input_audio     = word;
        input_audio_stb = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (input_audio_ack) begin
                @(posedge clk);
                #1 input_audio_stb = 1'b0;
                done = 1'b1;
            end
            @(negedge clk);
        end
        input_audio_stb = 1'b0;
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic window(output int hi);
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            hi += int'(audio_pwm);
        end
    endtask

    // Saturation: with a 1-clock period every cycle after the first pop is an empty tick.
    initial begin
        rst2   = 1'b0;
        stb2   = 1'b0;
        audio2 = 32'h0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        check("sat_ack_ready", 32'(ack2), 32'd1);
        stb2   = 1'b1;
        audio2 = 32'h0000_1234;
        @(posedge clk);
        #1 stb2 = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("sat_count_999", 32'(uc2), 32'd999);
        repeat (65000) @(negedge clk);
        check("sat_reached", 32'(uc2), 32'h0000_FFFF);
        repeat (20) @(negedge clk);
        check("sat_holds", 32'(uc2), 32'h0000_FFFF);
        done2 = 1'b1;
    end

    logic [31:0] bp_words [6];
    int          hi, n, acc, maxlvl, rise, run, maxrun;
    bit          seen_low, xfer, drained;
    logic [15:0] base;

    initial begin
        bp_words = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000,
                     32'h0000_4000, 32'h0000_5000, 32'h0000_6000};
        rst             = 1'b0;
        input_audio     = 32'h0;
        input_audio_stb = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(input_audio_ack), 32'd0);
        check("rst_pwm", 32'(audio_pwm), 32'd0);
        check("rst_sd", 32'(audio_sd), 32'd0);
        check("rst_uc", 32'(underrun_count), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b1;
        #1 check("ack_at_release", 32'(input_audio_ack), 32'd0);
        @(negedge clk);
        check("ack_one_cycle_after", 32'(input_audio_ack), 32'd1);

        // Idle with amplifier off: ticks occur but nothing counts and the pin stays low.
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            hi += int'(audio_pwm);
        end
        check("idle_pwm_low", 32'(hi), 32'd0);
        check("idle_uc_zero", 32'(underrun_count), 32'd0);
        check("idle_sd_low", 32'(audio_sd), 32'd0);

        send(32'h0000_7FFF, "send_7fff");
        check("sd_after_first", 32'(audio_sd), 32'd1);
        repeat (100) @(negedge clk);
        window(hi);
        check("duty_7fff", 32'(hi), 32'd15);

        send(32'h0000_8000, "send_8000");
        repeat (100) @(negedge clk);
        window(hi);
        check("duty_8000", 32'(hi), 32'd0);

        send(32'h0000_0000, "send_0000");
        repeat (100) @(negedge clk);
        window(hi);
        check("duty_0000", 32'(hi), 32'd8);

        send(32'hFFFF_4000, "send_hi_ignored");
        repeat (100) @(negedge clk);
        window(hi);
        check("duty_4000_upper_ignored", 32'(hi), 32'd12);

        // Backpressure: stb held across six words starting right after a tick.
        wait_tick("bp_sync");
        n        = 0;
        acc      = 0;
        maxlvl   = 0;
        rise     = -1;
        seen_low = 1'b0;
        input_audio     = bp_words[0];
        input_audio_stb = 1'b1;
        while (acc < 6 && n < 300) begin
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (!input_audio_ack) seen_low = 1'b1;
            else if (seen_low && rise < 0) rise = n;
            if (n == 63) begin
                check("bp_accepted_before_tick", 32'(acc), 32'd4);
                check("bp_ack_low_when_full", 32'(input_audio_ack), 32'd0);
                check("bp_level_full", 32'(fifo_level), 32'd4);
            end
            xfer = input_audio_ack;
            @(posedge clk);
            n++;
            #1;
            if (xfer) begin
                acc++;
                if (acc < 6) input_audio = bp_words[acc];
                else input_audio_stb = 1'b0;
            end
            @(negedge clk);
        end
        input_audio_stb = 1'b0;
        check("bp_all_accepted", 32'(acc), 32'd6);
        check("bp_ack_rise_after_tick", 32'(rise), 32'd64);
        check("bp_max_level", 32'(maxlvl), 32'd4);
        drained = 1'b0;
        for (int i = 0; i < 600 && !drained; i++) begin
            @(negedge clk);
            if (fifo_level == 3'd0) drained = 1'b1;
        end
        check("bp_drained", 32'(drained), 32'd1);

        // Underrun: one sample after a tick, then three empty ticks.
        wait_tick("ur_sync");
        base = underrun_count;
        send(32'h0000_4000, "ur_send");
        repeat (98) @(negedge clk);
        check("ur_no_count_on_pop", 32'(underrun_count), 32'(base));
        repeat (161) @(negedge clk);
        check("ur_three_ticks", 32'(underrun_count), 32'(base + 16'd3));
        window(hi);
        check("ur_duty_held", 32'(hi), 32'd12);

        // Push lands on the very tick edge that finds the FIFO empty.
        wait_tick("pp_sync");
        base = underrun_count;
        repeat (63) @(negedge clk);
        check("pp_ack_ready", 32'(input_audio_ack), 32'd1);
        input_audio     = 32'h0000_C000;
        input_audio_stb = 1'b1;
        @(posedge clk);
        #1 input_audio_stb = 1'b0;
        @(negedge clk);
        check("pp_underrun_counted", 32'(underrun_count), 32'(base + 16'd1));
        check("pp_level_one", 32'(fifo_level), 32'd1);
        repeat (63) @(negedge clk);
        check("pp_still_queued", 32'(fifo_level), 32'd1);
        @(negedge clk);
        check("pp_popped_next_tick", 32'(fifo_level), 32'd0);
        check("pp_no_extra_underrun", 32'(underrun_count), 32'(base + 16'd1));
        repeat (30) @(negedge clk);
        window(hi);
        check("pp_duty_c000", 32'(hi), 32'd4);

        // Mid-stream reset with three queued samples.
        wait_tick("mr_sync");
        send(32'h0000_7FFF, "mr_send0");
        send(32'h0000_7FFF, "mr_send1");
        send(32'h0000_7FFF, "mr_send2");
        check("mr_level_three", 32'(fifo_level), 32'd3);
        rst = 1'b0;
        #1;
        check("mr_level_cleared", 32'(fifo_level), 32'd0);
        check("mr_ack_cleared", 32'(input_audio_ack), 32'd0);
        check("mr_sd_cleared", 32'(audio_sd), 32'd0);
        check("mr_uc_cleared", 32'(underrun_count), 32'd0);
        check("mr_pwm_cleared", 32'(audio_pwm), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        hi     = 0;
        maxlvl = 0;
        repeat (300) begin
            @(negedge clk);
            hi += int'(audio_pwm);
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
        end
        check("mr_pwm_silent", 32'(hi), 32'd0);
        check("mr_fifo_stays_empty", 32'(maxlvl), 32'd0);
        send(32'h0000_8000, "mr_send_new");
        run    = 0;
        maxrun = 0;
        repeat (150) begin
            @(negedge clk);
            run = audio_pwm ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("mr_no_stale_duty", 32'(maxrun <= 8), 32'd1);
        window(hi);
        check("mr_new_duty", 32'(hi), 32'd0);

        for (int i = 0; i < 70000 && !done2; i++) @(negedge clk);
        check("sat_finished", 32'(done2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
